// File: rtl/hazard_unit_pkg.sv
// Shared core definitions for the pipeline hazard unit: register-address width
// and the hazard FSM state encoding.
package hazard_unit_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. The perf counter outputs exist only
// when HAZARD_PERF_CNT_EN is defined.
interface hazard_unit_if;
  import hazard_unit_pkg::*;

  logic [REG_ADDR_W-1:0] if_id_rs1_addr_i;
  logic [REG_ADDR_W-1:0] if_id_rs2_addr_i;
  logic                  if_id_uses_rs1_i;
  logic                  if_id_uses_rs2_i;
  logic [REG_ADDR_W-1:0] id_ex_rd_addr_i;
  logic                  id_ex_write_rd_i;
  logic                  id_ex_wb_use_mem_i;
  logic                  ex_mem_mem_req_i;
  logic                  dmem_ack_i;
  logic                  ex_branch_taken_i;

  logic                  stall_if_o;
  logic                  stall_id_o;
  logic                  stall_ex_o;
  logic                  stall_mem_o;
  logic                  bubble_ex_o;
  logic                  bubble_wb_o;
  logic                  flush_id_o;
  logic                  fault_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]           stall_cycles_o;
  logic [31:0]           bubble_cycles_o;
`endif

  // Pipeline side: drives hazard sources, consumes stall/flush controls.
  modport master (
    output if_id_rs1_addr_i, if_id_rs2_addr_i, if_id_uses_rs1_i, if_id_uses_rs2_i,
    output id_ex_rd_addr_i, id_ex_write_rd_i, id_ex_wb_use_mem_i,
    output ex_mem_mem_req_i, dmem_ack_i, ex_branch_taken_i,
    input  stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
    input  bubble_ex_o, bubble_wb_o, flush_id_o, fault_o
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cycles_o, bubble_cycles_o
`endif
  );

  // Hazard unit side.
  modport slave (
    input  if_id_rs1_addr_i, if_id_rs2_addr_i, if_id_uses_rs1_i, if_id_uses_rs2_i,
    input  id_ex_rd_addr_i, id_ex_write_rd_i, id_ex_wb_use_mem_i,
    input  ex_mem_mem_req_i, dmem_ack_i, ex_branch_taken_i,
    output stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
    output bubble_ex_o, bubble_wb_o, flush_id_o, fault_o
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cycles_o, bubble_cycles_o
`endif
  );

endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: dmem wait/timeout FSM, branch flush and load-use stall.
// Optional stall/bubble cycle counters enabled by HAZARD_PERF_CNT_EN.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_unit_if.slave hz
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  hazard_state_t    state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic mem_stall;
  logic rs1_hit, rs2_hit, load_use;
  logic pipe_free;
  logic stall_if, stall_id, stall_ex, stall_mem;
  logic bubble_ex, bubble_wb, flush_id, fault;

  assign mem_stall = hz.ex_mem_mem_req_i & ~hz.dmem_ack_i;
  assign rs1_hit   = hz.if_id_uses_rs1_i & (hz.if_id_rs1_addr_i == hz.id_ex_rd_addr_i);
  assign rs2_hit   = hz.if_id_uses_rs2_i & (hz.if_id_rs2_addr_i == hz.id_ex_rd_addr_i);
  assign load_use  = hz.id_ex_write_rd_i & hz.id_ex_wb_use_mem_i &
                     (hz.id_ex_rd_addr_i != '0) & (rs1_hit | rs2_hit);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pipe_free  = 1'b0;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    stall_mem  = 1'b0;
    bubble_ex  = 1'b0;
    bubble_wb  = 1'b0;
    flush_id   = 1'b0;
    fault      = 1'b0;

    if (!rst_i) begin
      case (state_q)
        ST_FAULT: begin
          {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
          bubble_wb = 1'b1;
          fault     = 1'b1;
        end
        ST_MEM_WAIT: begin
          if (hz.dmem_ack_i) begin
            // Frozen pipeline releases this cycle, so pending hazards are seen now.
            state_d    = ST_RUN;
            wait_cnt_d = '0;
            pipe_free  = 1'b1;
          end else begin
            {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
            bubble_wb = 1'b1;
            if (wait_cnt_q == TIMEOUT_CNT) begin
              state_d = ST_FAULT;
            end else if (wait_cnt_q != CNT_MAX) begin
              wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          if (mem_stall) begin
            {stall_if, stall_id, stall_ex, stall_mem} = 4'b1111;
            bubble_wb  = 1'b1;
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = CNT_W'(1);
          end else begin
            pipe_free = 1'b1;
          end
        end
      endcase

      // Branch squashes the consumer in decode, so it outranks load-use.
      if (pipe_free) begin
        if (hz.ex_branch_taken_i) begin
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
    end
  end

  assign hz.stall_if_o  = stall_if;
  assign hz.stall_id_o  = stall_id;
  assign hz.stall_ex_o  = stall_ex;
  assign hz.stall_mem_o = stall_mem;
  assign hz.bubble_ex_o = bubble_ex;
  assign hz.bubble_wb_o = bubble_wb;
  assign hz.flush_id_o  = flush_id;
  assign hz.fault_o     = fault;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, bubble_cycles_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cycles_q  <= '0;
      bubble_cycles_q <= '0;
    end else begin
      if (stall_if)  stall_cycles_q  <= stall_cycles_q + 32'd1;
      if (bubble_ex) bubble_cycles_q <= bubble_cycles_q + 32'd1;
    end
  end

  assign hz.stall_cycles_o  = stall_cycles_q;
  assign hz.bubble_cycles_o = bubble_cycles_q;
`endif

endmodule
